// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit
// per cycle MSB first, with valid/ready handshakes on both sides and divide-by-zero flagging.
module seq_divider #(
  parameter int N = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   C,
  input  logic [N-1:0]     B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   Q,
  output logic [N-1:0]     R,
  output logic             div_by_zero
);

  localparam int CW = $clog2(2 * N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]   p;
  logic [2*N-1:0] d;
  logic [N-1:0]   b_reg;
  logic [CW-1:0]  cnt;

  logic           accept;
  logic           last_bit;
  logic           q_bit;
  logic [N-1:0]   p_step;

  // One restoring step. The shifted partial remainder is N+1 bits, but after the
  // conditional subtract it is always below the divisor, so N bits suffice to keep it.
  function automatic logic [N:0] restore_step(input logic [N-1:0] p_cur,
                                              input logic         d_msb,
                                              input logic [N-1:0] div);
    logic [N:0] shifted;
    logic       ge;
    shifted = {p_cur, d_msb};
    ge      = (shifted >= {1'b0, div});
    if (ge) return {1'b1, shifted[N-1:0] - div};
    else    return {1'b0, shifted[N-1:0]};
  endfunction

  assign accept    = in_valid && in_ready;
  assign last_bit  = (cnt == '0);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign {q_bit, p_step} = restore_step(p, d[2*N-1], b_reg);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (B == '0) ? DONE : BUSY;
      BUSY:    if (last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers: reset clears them and discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CW'(2 * N - 1);
      else if (state == BUSY)
        cnt <= cnt - CW'(1);

      if (accept && (B == '0)) begin
        Q           <= '1;
        R           <= C[N-1:0];
        div_by_zero <= 1'b1;
      end else if ((state == BUSY) && last_bit) begin
        Q           <= {d[2*N-2:0], q_bit};
        R           <= p_step;
        div_by_zero <= 1'b0;
      end
    end
  end

  // Working registers: quotient bits shift into the low end of d as dividend bits leave the top.
  always_ff @(posedge clk) begin
    if (accept) begin
      p     <= '0;
      d     <= C;
      b_reg <= B;
    end else if (state == BUSY) begin
      p <= p_step;
      d <= {d[2*N-2:0], q_bit};
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at N=8: vector table, product round trips,
// backpressure and mid-operation reset sequences.
module tb_seq_divider;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*N-1:0] c_in = '0;
  logic [N-1:0]   b_in = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*N-1:0] q_out;
  logic [N-1:0]   r_out;
  logic           dbz;

  int tests = 0;
  int fails = 0;

  seq_divider #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .C          (c_in),
    .B          (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Q          (q_out),
    .R          (r_out),
    .div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] c;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for in_ready, transfers one operation, then counts edges until out_valid.
  // lat = number of edges after the accepting edge; 0 means valid right after accept.
  task automatic run_op(input logic [15:0] c, input logic [7:0] b, output int lat, output logic ok);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    c_in = c; b_in = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    ok = out_valid;
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_ov_drop"}, {31'b0, out_valid}, 32'd0);
    check({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int   lat;
    logic ok;
    logic [7:0] a_r, b_r;

    vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,    1'b0, 16};
    vecs[1] = '{16'hFE01,  8'd255, 16'd255,   8'd0,    1'b0, 16};
    vecs[2] = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0,    1'b0, 16};
    vecs[3] = '{16'd5,     8'd200, 16'd0,     8'd5,    1'b0, 16};
    vecs[4] = '{16'd0,     8'd9,   16'd0,     8'd0,    1'b0, 16};
    vecs[5] = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,   1'b1, 0};
    vecs[6] = '{16'd77,    8'd3,   16'd25,    8'd2,    1'b0, 16};
    vecs[7] = '{16'hFFFF,  8'd255, 16'd257,   8'd0,    1'b0, 16};
    vecs[8] = '{16'hFFFF,  8'd128, 16'd511,   8'd127,  1'b0, 16};
    vecs[9] = '{16'd300,   8'd255, 16'd1,     8'd45,   1'b0, 16};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_q", {16'b0, q_out}, 32'd0);
    check("rst_r", {24'b0, r_out}, 32'd0);
    check("rst_dbz", {31'b0, dbz}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].c, vecs[i].b, lat, ok);
      check($sformatf("v%0d_valid", i), {31'b0, ok}, 32'd1);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_q", i), {16'b0, q_out}, {16'b0, vecs[i].q});
      check($sformatf("v%0d_r", i), {24'b0, r_out}, {24'b0, vecs[i].r});
      check($sformatf("v%0d_dbz", i), {31'b0, dbz}, {31'b0, vecs[i].dbz});
      check($sformatf("v%0d_in_ready_done", i), {31'b0, in_ready}, 32'd0);
      release_result($sformatf("v%0d", i));
    end

    // Product round trips: (A*B)/B must give A with zero remainder
    for (int i = 0; i < 20; i++) begin
      a_r = 8'($urandom_range(0, 255));
      b_r = 8'($urandom_range(1, 255));
      run_op(16'(a_r) * 16'(b_r), b_r, lat, ok);
      check($sformatf("rt%0d_valid", i), {31'b0, ok}, 32'd1);
      check($sformatf("rt%0d_q", i), {16'b0, q_out}, {24'b0, a_r});
      check($sformatf("rt%0d_r", i), {24'b0, r_out}, 32'd0);
      release_result($sformatf("rt%0d", i));
    end

    // Backpressure: new operands offered during BUSY and DONE are ignored
    c_in = 16'd1000; b_in = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    c_in = 16'd50; b_in = 8'd5; in_valid = 1'b1;
    check("bp_busy_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      c_in = 16'd99; b_in = 8'd0; in_valid = 1'b1;
      check($sformatf("bp%0d_ov", k), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
      check($sformatf("bp%0d_q", k), {16'b0, q_out}, 32'd142);
      check($sformatf("bp%0d_r", k), {24'b0, r_out}, 32'd6);
      check($sformatf("bp%0d_dbz", k), {31'b0, dbz}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    release_result("bp");
    check("bp_q_held_idle", {16'b0, q_out}, 32'd142);
    repeat (3) begin @(posedge clk); #1; end
    check("bp_no_stray_op", {31'b0, out_valid}, 32'd0);
    check("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);

    // Reset five cycles into BUSY discards the operation
    c_in = 16'd1000; b_in = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mr_out_valid", {31'b0, out_valid}, 32'd0);
    check("mr_q", {16'b0, q_out}, 32'd0);
    check("mr_r", {24'b0, r_out}, 32'd0);
    check("mr_in_ready", {31'b0, in_ready}, 32'd1);
    ok = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (out_valid) ok = 1'b1;
    end
    check("mr_discarded", {31'b0, ok}, 32'd0);
    run_op(16'd77, 8'd3, lat, ok);
    check("mr_post_valid", {31'b0, ok}, 32'd1);
    check("mr_post_lat", lat, 16);
    check("mr_post_q", {16'b0, q_out}, 32'd25);
    check("mr_post_r", {24'b0, r_out}, 32'd2);
    release_result("mr_post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
